// File: rtl/phase_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : phase_scheduler_if
// Description : Bundle between the intersection phase scheduler and its
//               neighbours: debounced demand/service inputs, per-phase done
//               returns, and the enable/clear/status outputs toward the
//               light modules.
// Revision    : 1.0 - initial release
// ============================================================================
interface phase_scheduler_if;
    // Demand and service inputs, bit order: sud, est, vest, nord, pietoni
    logic [4:0] req_i;
    logic       service_i;
    logic [4:0] done_i;

    // Outputs toward the light modules and status
    logic [4:0] enable_o;
    logic [4:0] clear_o;
    logic       service_o;
    logic [2:0] phase_o;
    logic [4:0] pending_o;

    // Environment side: drives demand/done, observes the scheduler
    modport master (
        output req_i,
        output service_i,
        output done_i,
        input  enable_o,
        input  clear_o,
        input  service_o,
        input  phase_o,
        input  pending_o
    );

    // Scheduler side
    modport slave (
        input  req_i,
        input  service_i,
        input  done_i,
        output enable_o,
        output clear_o,
        output service_o,
        output phase_o,
        output pending_o
    );
endinterface
`default_nettype wire

// File: rtl/phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : phase_scheduler
// Description : Demand-actuated phase scheduler. Latches vehicle/pedestrian
//               requests, grants phases round-robin with pedestrian ageing
//               pre-emption, sequences clear/enable/done handshakes with an
//               all-red clearance between phases, and supports a service
//               override.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_scheduler #(
    parameter int DIV_FACTOR   = 10000000,
    parameter int ALL_RED_SEC  = 2,
    parameter int MAX_WAIT_SEC = 90
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    phase_scheduler_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PRESC_W = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
    localparam int c_AR_W    = $clog2(ALL_RED_SEC + 1);
    localparam int c_WAIT_W  = $clog2(MAX_WAIT_SEC + 1);

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(DIV_FACTOR - 1);
    localparam logic [c_AR_W-1:0]    c_AR_LAST    = c_AR_W'(ALL_RED_SEC - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX   = c_WAIT_W'(MAX_WAIT_SEC);

    localparam logic [2:0] c_PH_PED  = 3'd4;
    localparam logic [2:0] c_PH_NONE = 3'd7;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_GRANT   = 3'd1;
    localparam logic [2:0] c_ST_RUN     = 3'd2;
    localparam logic [2:0] c_ST_ALL_RED = 3'd3;
    localparam logic [2:0] c_ST_SERVICE = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [2:0]           r_sel;
    logic [2:0]           r_phase;
    logic [4:0]           r_pending;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_AR_W-1:0]    r_ar_cnt;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic                 r_svc_first;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0] w_state_nxt;
    logic       w_tick;
    logic [4:0] w_sel_onehot;
    logic [4:0] w_grant_mask;
    logic       w_grant_entry;
    logic       w_ar_entry;
    logic       w_svc_entry;
    logic       w_ped_running;
    logic [2:0] w_scan_start;
    logic [3:0] w_scan_idx;
    logic [2:0] w_scan_pick;
    logic       w_scan_hit;
    logic [2:0] w_sel;

    assign w_tick        = (r_presc == c_PRESC_LAST);
    assign w_sel_onehot  = 5'(5'd1 << r_sel);
    assign w_grant_mask  = (r_state == c_ST_GRANT) ? w_sel_onehot : 5'd0;
    assign w_grant_entry = (w_state_nxt == c_ST_GRANT);
    assign w_ar_entry    = (w_state_nxt == c_ST_ALL_RED) && (r_state != c_ST_ALL_RED);
    assign w_svc_entry   = (w_state_nxt == c_ST_SERVICE) && (r_state != c_ST_SERVICE);
    assign w_ped_running = (r_state == c_ST_RUN) && (r_sel == c_PH_PED);

    // Next-phase choice: aged pedestrian first, else rotate from the last grant
    always_comb begin
        w_scan_start = (r_phase >= 3'd4) ? 3'd0 : (r_phase + 3'd1);
        w_scan_idx   = 4'd0;
        w_scan_pick  = 3'd0;
        w_scan_hit   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_scan_idx = {1'b0, w_scan_start} + 4'(i);
            if (w_scan_idx >= 4'd5) begin
                w_scan_idx = w_scan_idx - 4'd5;
            end
            if (!w_scan_hit && r_pending[w_scan_idx[2:0]]) begin
                w_scan_hit  = 1'b1;
                w_scan_pick = w_scan_idx[2:0];
            end
        end
        if (r_pending[4] && (r_wait_cnt >= c_WAIT_MAX)) begin
            w_sel = c_PH_PED;
        end else begin
            w_sel = w_scan_pick;
        end
    end

    // Next-state logic; service mode overrides every other condition
    always_comb begin
        w_state_nxt = r_state;
        if (bus.service_i) begin
            w_state_nxt = c_ST_SERVICE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (|r_pending) begin
                        w_state_nxt = c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    w_state_nxt = c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (bus.done_i[r_sel]) begin
                        w_state_nxt = c_ST_ALL_RED;
                    end
                end
                c_ST_ALL_RED: begin
                    if (w_tick && (r_ar_cnt == c_AR_LAST)) begin
                        w_state_nxt = (|r_pending) ? c_ST_GRANT : c_ST_IDLE;
                    end
                end
                c_ST_SERVICE: begin
                    w_state_nxt = c_ST_ALL_RED;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // State register plus the one-shot flag marking the first service cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_svc_first <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_svc_first <= w_svc_entry;
        end
    end

    // Granted phase is captured on entry to GRANT and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= 3'd0;
            r_phase <= c_PH_NONE;
        end else if (w_grant_entry) begin
            r_sel   <= w_sel;
            r_phase <= w_sel;
        end
    end

    // Request latch; the granted bit is cleared and a same-cycle request absorbed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 5'd0;
        end else begin
            r_pending <= (r_pending | bus.req_i) & ~w_grant_mask;
        end
    end

    // One-second prescaler, realigned at the start of every clearance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_ar_entry || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Seconds spent in the current all-red clearance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_cnt <= '0;
        end else if (w_ar_entry) begin
            r_ar_cnt <= '0;
        end else if ((r_state == c_ST_ALL_RED) && w_tick) begin
            r_ar_cnt <= r_ar_cnt + 1'b1;
        end
    end

    // Pedestrian ageing: counts waiting seconds, saturating, frozen in service
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == c_ST_GRANT) && (r_sel == c_PH_PED)) begin
            r_wait_cnt <= '0;
        end else if (w_tick && r_pending[4] && (r_state != c_ST_SERVICE) &&
                     !w_ped_running && (r_wait_cnt < c_WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Outputs decoded from registered state
    assign bus.enable_o  = (r_state == c_ST_RUN) ? w_sel_onehot : 5'd0;
    assign bus.clear_o   = (r_state == c_ST_GRANT) ? w_sel_onehot :
                           ((r_state == c_ST_SERVICE) && r_svc_first) ? 5'b11111 : 5'd0;
    assign bus.service_o = (r_state == c_ST_SERVICE);
    assign bus.phase_o   = r_phase;
    assign bus.pending_o = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_scheduler
// Description : Scoreboard bench for phase_scheduler. Stimulus pushes the
//               expected clear pulses (cycle, vector, phase) into a queue and
//               a negedge monitor pops and compares whenever clear_o is
//               non-zero; level checks are made directly from stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_scheduler;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  clr;
        logic [2:0]  ph;
    } exp_t;

    exp_t exp_q[$];

    phase_scheduler_if bus_if ();

    phase_scheduler #(
        .DIV_FACTOR   (4),
        .ALL_RED_SEC  (2),
        .MAX_WAIT_SEC (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [4:0] clr, input logic [2:0] ph);
        exp_t e;
        e.cyc = 32'(c);
        e.clr = clr;
        e.ph  = ph;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse; returns 1ns after the first edge with reset released
    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.req_i     = 5'd0;
        bus_if.service_i = 1'b0;
        bus_if.done_i    = 5'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Called on the GRANT cycle of ph; returns on the cycle after clearance
    task automatic serve_one(input logic [2:0] ph, input logic has_next,
                             input logic [2:0] nxt, input int hold);
        logic [4:0] oh;
        logic [4:0] ohn;
        oh  = 5'(5'd1 << ph);
        ohn = 5'(5'd1 << nxt);
        bus_if.done_i = ~oh;
        step();
        chk("enable_run", int'(bus_if.enable_o), int'(oh));
        if (hold > 0) begin
            step();
            bus_if.done_i = 5'd0;
            repeat (hold - 1) step();
        end
        bus_if.done_i = oh;
        if (has_next) push_exp(cyc + 9, ohn, nxt);
        step();
        bus_if.done_i = 5'd0;
        chk("enable_after_done", int'(bus_if.enable_o), 0);
        repeat (8) step();
    endtask

    // Scoreboard monitor: every clear pulse must match the next expectation
    always @(negedge clk) begin
        if (rst_n && (bus_if.clear_o != 5'd0)) begin
            if (exp_q.size() == 0) begin
                chk("clear_unexpected", int'(bus_if.clear_o), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("clear_cycle", cyc, int'(e.cyc));
                chk("clear_vector", int'(bus_if.clear_o), int'(e.clr));
                chk("phase_at_clear", int'(bus_if.phase_o), int'(e.ph));
            end
        end
    end

    initial begin
        cyc   = 0;
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus_if.req_i     = 5'd0;
        bus_if.service_i = 1'b0;
        bus_if.done_i    = 5'd0;

        // Power-on reset values
        #2 rst_n = 1'b0;
        #2;
        chk("rst_enable",  int'(bus_if.enable_o),  0);
        chk("rst_clear",   int'(bus_if.clear_o),   0);
        chk("rst_service", int'(bus_if.service_o), 0);
        chk("rst_phase",   int'(bus_if.phase_o),   7);
        chk("rst_pending", int'(bus_if.pending_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request for phase 1
        step();
        bus_if.req_i = 5'b00010;
        push_exp(cyc + 2, 5'b00010, 3'd1);
        step();
        bus_if.req_i = 5'd0;
        chk("s1_pending_latched", int'(bus_if.pending_o), 2);
        chk("s1_enable_idle", int'(bus_if.enable_o), 0);
        step();
        serve_one(3'd1, 1'b0, 3'd0, 5);
        chk("s1_pending_cleared", int'(bus_if.pending_o), 0);
        chk("s1_phase_held", int'(bus_if.phase_o), 1);
        repeat (3) step();

        // All phases requested at once; pedestrian ages past 5 s after phase 2
        do_reset();
        step();
        bus_if.req_i = 5'b11111;
        push_exp(cyc + 2, 5'b00001, 3'd0);
        step();
        bus_if.req_i = 5'd0;
        step();
        serve_one(3'd0, 1'b1, 3'd1, 0);
        serve_one(3'd1, 1'b1, 3'd2, 0);
        serve_one(3'd2, 1'b1, 3'd4, 0);
        serve_one(3'd4, 1'b1, 3'd3, 0);
        serve_one(3'd3, 1'b0, 3'd0, 0);
        chk("s2_pending_empty", int'(bus_if.pending_o), 0);

        // Long phase 0 run ages the pedestrian request, which then pre-empts
        do_reset();
        step();
        bus_if.req_i = 5'b11111;
        push_exp(cyc + 2, 5'b00001, 3'd0);
        step();
        bus_if.req_i = 5'd0;
        step();
        serve_one(3'd0, 1'b1, 3'd4, 29);
        serve_one(3'd4, 1'b1, 3'd1, 0);
        serve_one(3'd1, 1'b1, 3'd2, 0);
        serve_one(3'd2, 1'b1, 3'd3, 0);
        serve_one(3'd3, 1'b0, 3'd0, 0);
        chk("s3_pending_empty", int'(bus_if.pending_o), 0);

        // Service override during phase 2 run
        do_reset();
        step();
        bus_if.req_i = 5'b00100;
        push_exp(cyc + 2, 5'b00100, 3'd2);
        step();
        bus_if.req_i = 5'd0;
        step();
        step();
        chk("s4_enable_run", int'(bus_if.enable_o), 4);
        step();
        bus_if.service_i = 1'b1;
        push_exp(cyc + 1, 5'b11111, 3'd2);
        step();
        chk("s4_enable_svc", int'(bus_if.enable_o), 0);
        chk("s4_service_on", int'(bus_if.service_o), 1);
        bus_if.req_i = 5'b01001;
        step();
        bus_if.req_i = 5'd0;
        chk("s4_clear_once", int'(bus_if.clear_o), 0);
        step();
        chk("s4_pending_svc", int'(bus_if.pending_o), 9);
        chk("s4_phase_held", int'(bus_if.phase_o), 2);
        bus_if.service_i = 1'b0;
        push_exp(cyc + 9, 5'b01000, 3'd3);
        step();
        chk("s4_service_off", int'(bus_if.service_o), 0);
        repeat (8) step();
        serve_one(3'd3, 1'b1, 3'd0, 0);
        serve_one(3'd0, 1'b0, 3'd0, 0);
        chk("s4_no_relatch", int'(bus_if.pending_o), 0);

        // Request collisions with phase 3 grant and run
        do_reset();
        step();
        bus_if.req_i = 5'b01000;
        push_exp(cyc + 2, 5'b01000, 3'd3);
        step();
        bus_if.req_i = 5'd0;
        step();
        bus_if.req_i = 5'b01000;
        step();
        bus_if.req_i = 5'd0;
        chk("s5_absorbed", int'(bus_if.pending_o), 0);
        chk("s5_enable_run", int'(bus_if.enable_o), 8);
        step();
        bus_if.req_i = 5'b01000;
        step();
        bus_if.req_i = 5'd0;
        chk("s5_relatched", int'(bus_if.pending_o), 8);
        bus_if.done_i = 5'b01000;
        push_exp(cyc + 9, 5'b01000, 3'd3);
        step();
        bus_if.done_i = 5'd0;
        chk("s5_enable_off", int'(bus_if.enable_o), 0);
        repeat (8) step();
        serve_one(3'd3, 1'b0, 3'd0, 0);
        chk("s5_pending_empty", int'(bus_if.pending_o), 0);

        // Asynchronous reset in the middle of a clearance
        do_reset();
        step();
        bus_if.req_i = 5'b00001;
        push_exp(cyc + 2, 5'b00001, 3'd0);
        step();
        bus_if.req_i = 5'd0;
        step();
        step();
        bus_if.req_i  = 5'b00010;
        bus_if.done_i = 5'b00001;
        step();
        bus_if.req_i  = 5'd0;
        bus_if.done_i = 5'd0;
        chk("s6_pending_before", int'(bus_if.pending_o), 2);
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("s6_rst_enable",  int'(bus_if.enable_o),  0);
        chk("s6_rst_clear",   int'(bus_if.clear_o),   0);
        chk("s6_rst_service", int'(bus_if.service_o), 0);
        chk("s6_rst_phase",   int'(bus_if.phase_o),   7);
        chk("s6_rst_pending", int'(bus_if.pending_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step();
        chk("s6_idle_phase", int'(bus_if.phase_o), 7);
        bus_if.req_i = 5'b00100;
        push_exp(cyc + 2, 5'b00100, 3'd2);
        step();
        bus_if.req_i = 5'd0;
        step();
        serve_one(3'd2, 1'b0, 3'd0, 0);

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
